// File: rtl/spi_ram_ctrl_if.sv
// Command/response bundle between the SPI serial front end and the RAM command engine.
// Handshake: din is consumed on every rising clk edge where rx_valid=1 (no backpressure);
// tx_valid pulses for exactly one cycle when dout carries freshly read data.
interface spi_ram_ctrl_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic [DATA_W+1:0] din;
   logic              rx_valid;
   logic [DATA_W-1:0] dout;
   logic              tx_valid;
   logic              addr_err;
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;

   modport master (
      output din, rx_valid,
      input  dout, tx_valid, addr_err, wr_ptr, rd_ptr
   );

   modport slave (
      input  din, rx_valid,
      output dout, tx_valid, addr_err, wr_ptr, rd_ptr
   );
endinterface

// File: rtl/spi_ram_ctrl.sv
// RAM command engine: decodes 2-bit-tagged command words into pointer loads, writes and reads.
// Optional macro AUTO_INC_EN: WR_DATA/RD_DATA post-increment their pointer, wrapping at MEM_DEPTH.
module spi_ram_ctrl #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int MEM_DEPTH = 256
) (
   input logic         clk,
   input logic         rst,
   spi_ram_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      OP_WR_ADDR = 2'b00,
      OP_WR_DATA = 2'b01,
      OP_RD_ADDR = 2'b10,
      OP_RD_DATA = 2'b11
   } op_e;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

   logic [DATA_W-1:0] mem [MEM_DEPTH];

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              tx_valid_q, tx_valid_d;
   logic              addr_err_q, addr_err_d;
   logic              mem_we;

   op_e               op;
   logic [DATA_W-1:0] payload;
   logic [ADDR_W-1:0] addr;
   logic              addr_ok;

   assign op      = op_e'(bus.din[DATA_W+1:DATA_W]);
   assign payload = bus.din[DATA_W-1:0];
   assign addr    = payload[ADDR_W-1:0];
   assign addr_ok = ({1'b0, addr} < DEPTH_C);

`ifdef AUTO_INC_EN
   localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(MEM_DEPTH - 1);

   function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
      return (p == LAST_C) ? '0 : p + 1'b1;
   endfunction
`endif

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      dout_d     = dout_q;
      addr_err_d = addr_err_q;
      tx_valid_d = 1'b0;
      mem_we     = 1'b0;
      if (bus.rx_valid) begin
         unique case (op)
            OP_WR_ADDR: begin
               if (addr_ok) wr_ptr_d = addr;
               else         addr_err_d = 1'b1;
            end
            OP_WR_DATA: begin
               mem_we = !rst;
`ifdef AUTO_INC_EN
               wr_ptr_d = next_ptr(wr_ptr_q);
`endif
            end
            OP_RD_ADDR: begin
               if (addr_ok) rd_ptr_d = addr;
               else         addr_err_d = 1'b1;
            end
            OP_RD_DATA: begin
               // Read is registered from the array; the write from the previous edge is already visible.
               dout_d     = mem[rd_ptr_q];
               tx_valid_d = 1'b1;
`ifdef AUTO_INC_EN
               rd_ptr_d = next_ptr(rd_ptr_q);
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         dout_q     <= dout_d;
         tx_valid_q <= tx_valid_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Storage is deliberately not reset so contents survive a mid-burst reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[wr_ptr_q] <= payload;
   end

   assign bus.dout     = dout_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.addr_err = addr_err_q;
   assign bus.wr_ptr   = wr_ptr_q;
   assign bus.rd_ptr   = rd_ptr_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomised scoreboard bench for spi_ram_ctrl with a behavioural memory model (MEM_DEPTH=200).
module tb_spi_ram_ctrl;
   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 8;
   localparam int MEM_DEPTH = 200;
   localparam int W         = 1 + DATA_W + 2*ADDR_W + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   spi_ram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   spi_ram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // expected response per driven cycle: {tx_valid, dout, wr_ptr, rd_ptr, addr_err}
   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   int m_mem [MEM_DEPTH];
   int m_wr, m_rd, m_dout;
   bit m_err;

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wr = 0; m_rd = 0; m_dout = 0; m_err = 0;
   endtask

   task automatic issue(input logic [1:0] op, input logic [DATA_W-1:0] pl, input logic v);
      int a;
      bit tx;
      @(negedge clk);
      bus.din      = {op, pl};
      bus.rx_valid = v;
      tx = 0;
      a  = int'(pl[ADDR_W-1:0]);
      if (v) begin
         case (op)
            2'd0: if (a < MEM_DEPTH) m_wr = a; else m_err = 1;
            2'd1: begin
               m_mem[m_wr] = int'(pl);
`ifdef AUTO_INC_EN
               m_wr = (m_wr + 1) % MEM_DEPTH;
`endif
            end
            2'd2: if (a < MEM_DEPTH) m_rd = a; else m_err = 1;
            default: begin
               m_dout = m_mem[m_rd];
               tx = 1;
`ifdef AUTO_INC_EN
               m_rd = (m_rd + 1) % MEM_DEPTH;
`endif
            end
         endcase
      end
      exp_q.push_back({tx, DATA_W'(m_dout), ADDR_W'(m_wr), ADDR_W'(m_rd), m_err});
   endtask

   task automatic idle();
      issue(2'd0, '0, 1'b0);
      bus.rx_valid = 1'b0;
   endtask

   // Asserts rst just after a rising edge and checks outputs before the next edge.
   task automatic reset_mid();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("rst_dout", int'(bus.dout), 0);
      check("rst_tx_valid", int'(bus.tx_valid), 0);
      check("rst_addr_err", int'(bus.addr_err), 0);
      check("rst_wr_ptr", int'(bus.wr_ptr), 0);
      check("rst_rd_ptr", int'(bus.rd_ptr), 0);
      model_reset();
      @(negedge clk);
      bus.rx_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // monitor: compares every driven cycle one edge later
   initial begin
      logic [W-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tx_valid", int'(bus.tx_valid), int'(e[W-1]));
            check("dout",     int'(bus.dout),     int'(e[W-2 -: DATA_W]));
            check("wr_ptr",   int'(bus.wr_ptr),   int'(e[2*ADDR_W : ADDR_W+1]));
            check("rd_ptr",   int'(bus.rd_ptr),   int'(e[ADDR_W:1]));
            check("addr_err", int'(bus.addr_err), int'(e[0]));
         end
      end
   end

   initial begin
      int budget;
      bus.din      = '0;
      bus.rx_valid = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // fill every location so reads are always defined
      for (int i = 0; i < MEM_DEPTH; i++) begin
         issue(2'd0, DATA_W'(i), 1'b1);
         issue(2'd1, DATA_W'($urandom_range(0, 255)), 1'b1);
      end
      idle();

      // reset while idle, checked before the next edge
      reset_mid();

      // single access
      issue(2'd0, 8'h12, 1'b1);
      issue(2'd1, 8'hA5, 1'b1);
      issue(2'd2, 8'h12, 1'b1);
      issue(2'd3, 8'h00, 1'b1);
      idle();
      idle();

      // burst across the wrap point
      issue(2'd0, DATA_W'(MEM_DEPTH-2), 1'b1);
      issue(2'd1, 8'h11, 1'b1);
      issue(2'd1, 8'h22, 1'b1);
      issue(2'd1, 8'h33, 1'b1);
      issue(2'd2, DATA_W'(MEM_DEPTH-2), 1'b1);
      issue(2'd3, 8'h00, 1'b1);
      issue(2'd3, 8'h00, 1'b1);
      issue(2'd3, 8'h00, 1'b1);
      idle();

      // repeated writes at one address
      issue(2'd0, 8'h05, 1'b1);
      issue(2'd1, 8'h11, 1'b1);
      issue(2'd1, 8'h22, 1'b1);
      issue(2'd2, 8'h05, 1'b1);
      issue(2'd3, 8'h00, 1'b1);
      idle();

      // range check at the depth boundary, then reset clears the sticky flag
      issue(2'd2, 8'h03, 1'b1);
      issue(2'd2, 8'hC8, 1'b1);
      issue(2'd0, 8'hFF, 1'b1);
      idle();
      reset_mid();
      issue(2'd2, 8'hC7, 1'b1);
      issue(2'd3, 8'h00, 1'b1);
      idle();

      // gating: RD_DATA opcode held without rx_valid, then a single pulse
      for (int i = 0; i < 5; i++) issue(2'd3, 8'h00, 1'b0);
      issue(2'd3, 8'h00, 1'b1);
      idle();
      idle();

      // reset mid-burst drops the pending pulse
      issue(2'd2, 8'h10, 1'b1);
      issue(2'd3, 8'h00, 1'b1);
      reset_mid();
      issue(2'd3, 8'h00, 1'b1);
      idle();

      // random traffic with an occasional reset
      for (int i = 0; i < 600; i++) begin
         if (i == 300) begin
            idle();
            reset_mid();
         end
         issue(2'($urandom_range(0, 3)), DATA_W'($urandom_range(0, 255)),
               ($urandom_range(0, 3) != 0));
      end
      idle();

      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
